// File: rtl/nes_controller_emulator.sv
// -----------------------------------------------------------------------------
// nes_controller_emulator
//
// Emulates an NES joypad shift register on the console side of the cable.
// The host's latch and shift clock arrive asynchronously and are synchronized
// into the sys_clock domain. A latch loads the eight button states; each
// following shift-clock rising edge presents the next bit on nes_data.
//
// Ports
//   sys_clock   in   system clock, all logic on its rising edge
//   reset_n     in   synchronous active-low reset
//   nes_latch   in   host latch (async), high = load buttons
//   nes_clock   in   host shift clock (async), rising edge = next bit
//   a .. right  in   button states, 1 = pressed
//   nes_data    out  serial data, active-low per bit, registered
//   frame_done  out  one-cycle pulse after the 8th bit is consumed
//   busy        out  high in LOAD or SHIFT
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module nes_controller_emulator #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic sys_clock,
    input  logic reset_n,
    input  logic nes_latch,
    input  logic nes_clock,
    input  logic a,
    input  logic b,
    input  logic select,
    input  logic start,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    output logic nes_data,
    output logic frame_done,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Synchronizer chains; the last stage is the usable synchronized value.
    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   latch_s;
    logic                   clk_s;
    logic                   latch_prev;
    logic                   clk_prev;
    logic                   latch_fall;
    logic                   clk_rise;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] sreg_q, sreg_d;
    logic       data_d;
    logic       done_d;
    logic [7:0] buttons;

    // Bit 0 is shifted out first.
    assign buttons    = {right, left, down, up, start, select, b, a};
    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign latch_fall = latch_prev & ~latch_s;
    assign clk_rise   = clk_s & ~clk_prev;
    assign busy       = (state_q == LOAD) || (state_q == SHIFT);

    // NOTE: every flop here, synchronizers included, is updated with <= so all
    // stages sample the pre-edge values and the chain really is N flops deep.
    always_ff @(posedge sys_clock) begin
        if (!reset_n) begin
            latch_sync <= '0;
            clk_sync   <= '0;
            latch_prev <= 1'b0;
            clk_prev   <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            sreg_q     <= {8{IDLE_LEVEL}};
            nes_data   <= IDLE_LEVEL;
            frame_done <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], nes_latch};
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], nes_clock};
            latch_prev <= latch_s;
            clk_prev   <= clk_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            nes_data   <= data_d;
            frame_done <= done_d;
        end
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        data_d  = nes_data;
        done_d  = 1'b0;

        if (latch_s) begin
            // Latch wins over any coincident shift edge; load is transparent.
            state_d = LOAD;
            sreg_d  = ~buttons;
            cnt_d   = 3'd0;
            data_d  = ~a;
        end else begin
            unique case (state_q)
                IDLE: begin
                    data_d = IDLE_LEVEL;
                end
                LOAD: begin
                    // Register stays frozen at the last loaded value.
                    if (latch_fall) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (clk_rise) begin
                        sreg_d = {IDLE_LEVEL, sreg_q[7:1]};
                        if (cnt_q == 3'd7) begin
                            state_d = DONE;
                            cnt_d   = 3'd0;
                            data_d  = IDLE_LEVEL;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d  = cnt_q + 3'd1;
                            data_d = sreg_q[1];
                        end
                    end
                end
                DONE: begin
                    data_d = IDLE_LEVEL;
                end
                default: begin
                    state_d = IDLE;
                    data_d  = IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_controller_emulator.sv
// -----------------------------------------------------------------------------
// tb_nes_controller_emulator
//
// Drives host latch / shift-clock waveforms at NES timing into the emulator
// and compares the serial stream against a queue of expected bits captured
// from the button snapshot at latch time.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nes_controller_emulator;

    localparam int CLK_NS     = 20;   // 50 MHz system clock
    localparam int LATCH_CYC  = 600;  // 12 us latch pulse
    localparam int HALF_CYC   = 150;  // 3 us half of a 6 us shift pulse
    localparam int GAP_CYC    = 300;

    logic       sys_clock = 1'b0;
    logic       reset_n   = 1'b0;
    logic       nes_latch = 1'b0;
    logic       nes_clock = 1'b0;
    logic [7:0] btn       = 8'h00;   // bit0 = A ... bit7 = Right
    logic       nes_data;
    logic       frame_done;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int done_total = 0;
    logic exp_q[$];

    always #(CLK_NS/2) sys_clock = ~sys_clock;

    nes_controller_emulator dut (
        .sys_clock  (sys_clock),
        .reset_n    (reset_n),
        .nes_latch  (nes_latch),
        .nes_clock  (nes_clock),
        .a          (btn[0]),
        .b          (btn[1]),
        .select     (btn[2]),
        .start      (btn[3]),
        .up         (btn[4]),
        .down       (btn[5]),
        .left       (btn[6]),
        .right      (btn[7]),
        .nes_data   (nes_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // Count every cycle frame_done is seen high.
    always @(negedge sys_clock) begin
        if (frame_done === 1'b1) done_total++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sys_clock);
    endtask

    task automatic push_frame(input int extra);
        for (int i = 0; i < 8; i++) exp_q.push_back(~btn[i]);
        for (int i = 0; i < extra; i++) exp_q.push_back(1'b1);
    endtask

    // Latch pulse; optionally measures the pin-to-output latency (needs a = 1
    // and an idle output beforehand so the change is visible).
    task automatic latch_frame(input int extra, input bit chk_lat, input string tag);
        @(posedge sys_clock);
        #1 nes_latch = 1'b1;
        if (chk_lat) begin
            repeat (2) @(posedge sys_clock);
            @(negedge sys_clock);
            n_checks++;
            if (nes_data !== 1'b1) begin
                n_fail++;
                $display("FAIL %s early_latency: nes_data=%b expected 1", tag, nes_data);
            end
            @(posedge sys_clock);
            @(negedge sys_clock);
            n_checks++;
            if (nes_data !== ~btn[0]) begin
                n_fail++;
                $display("FAIL %s latch_latency: nes_data=%b expected %b", tag, nes_data, ~btn[0]);
            end
        end
        wait_cycles(LATCH_CYC);
        nes_latch = 1'b0;
        exp_q.delete();
        push_frame(extra);
        wait_cycles(GAP_CYC);
        @(negedge sys_clock);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_latch: busy=%b expected 1", tag, busy);
        end
    endtask

    // Sample nes_data before each rising edge and compare with the scoreboard.
    task automatic clock_pulses(input int n, input string tag);
        logic exp;
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clock);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
            n_checks++;
            if (nes_data !== exp) begin
                n_fail++;
                $display("FAIL %s bit%0d: nes_data=%b expected %b", tag, i, nes_data, exp);
            end
            nes_clock = 1'b1;
            wait_cycles(HALF_CYC);
            nes_clock = 1'b0;
            wait_cycles(HALF_CYC);
        end
    endtask

    task automatic check_end(input int done_before, input int done_exp,
                             input logic busy_exp, input string tag);
        @(negedge sys_clock);
        n_checks++;
        if (nes_data !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_data: nes_data=%b expected 1", tag, nes_data);
        end
        n_checks++;
        if ((done_total - done_before) !== done_exp) begin
            n_fail++;
            $display("FAIL %s frame_done_cycles: got %0d expected %0d", tag,
                     done_total - done_before, done_exp);
        end
        n_checks++;
        if (busy !== busy_exp) begin
            n_fail++;
            $display("FAIL %s busy_end: busy=%b expected %b", tag, busy, busy_exp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(posedge sys_clock);
        for (int i = 0; i < 23; i++) begin
            if (i == 3) reset_n = 1'b1;
            @(posedge sys_clock);
            #1 nes_clock = ~nes_clock;
            @(negedge sys_clock);
            n_checks++;
            if ({nes_data, frame_done, busy} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset cyc%0d: data/done/busy=%b expected 100", i,
                         {nes_data, frame_done, busy});
            end
        end
        nes_clock = 1'b0;
        wait_cycles(10);
    endtask

    task automatic test_frame();
        int d0;
        btn = 8'b0001_0001;   // A and Up
        latch_frame(0, 1'b1, "frame");
        d0 = done_total;
        clock_pulses(8, "frame");
        check_end(d0, 1, 1'b0, "frame");
    endtask

    task automatic test_midframe();
        int d0;
        btn = 8'b0100_0010;   // B and Left
        latch_frame(0, 1'b0, "mid");
        d0 = done_total;
        clock_pulses(2, "mid");
        btn[3] = 1'b1;        // Start pressed mid-frame
        clock_pulses(6, "mid");
        check_end(d0, 1, 1'b0, "mid");
        latch_frame(0, 1'b0, "mid_next");
        d0 = done_total;
        clock_pulses(8, "mid_next");
        check_end(d0, 1, 1'b0, "mid_next");
    endtask

    task automatic test_abort();
        int d0;
        btn = 8'b1000_0001;   // A and Right, Start released
        latch_frame(0, 1'b0, "abort");
        d0 = done_total;
        clock_pulses(3, "abort");
        @(posedge sys_clock);
        #1 nes_latch = 1'b1;
        repeat (3) @(posedge sys_clock);
        @(negedge sys_clock);
        n_checks++;
        if (nes_data !== ~btn[0]) begin
            n_fail++;
            $display("FAIL abort reload: nes_data=%b expected %b", nes_data, ~btn[0]);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort busy: busy=%b expected 1", busy);
        end
        wait_cycles(LATCH_CYC);
        nes_latch = 1'b0;
        n_checks++;
        if (done_total !== d0) begin
            n_fail++;
            $display("FAIL abort no_done: got %0d pulses expected 0", done_total - d0);
        end
        exp_q.delete();
        push_frame(0);
        wait_cycles(GAP_CYC);
        clock_pulses(8, "abort_next");
        check_end(d0, 1, 1'b0, "abort_next");
    endtask

    task automatic test_overclock();
        int d0;
        btn = 8'b0010_0100;   // Select and Down
        latch_frame(4, 1'b0, "over");
        d0 = done_total;
        clock_pulses(12, "over");
        check_end(d0, 1, 1'b0, "over");
    endtask

    task automatic test_reset_midshift();
        int d0;
        btn = 8'b0000_0000;
        latch_frame(0, 1'b0, "rst_mid");
        d0 = done_total;
        clock_pulses(4, "rst_mid");
        @(posedge sys_clock);
        #1 reset_n = 1'b0;
        @(posedge sys_clock);
        #1 reset_n = 1'b1;
        @(negedge sys_clock);
        n_checks++;
        if ({nes_data, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid after_reset: data/busy=%b expected 10", {nes_data, busy});
        end
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
        clock_pulses(4, "rst_mid_post");
        check_end(d0, 0, 1'b0, "rst_mid_post");
    endtask

    initial begin
        #1500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_frame();
        test_midframe();
        test_abort();
        test_overclock();
        test_reset_midshift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
